life_engine: RTL and testbench



---
 rtl/life_pkg.sv | 36 +++
 rtl/life_popcnt.sv | 18 +
 rtl/life_engine.sv | 128 ++++++++++++
 tb/tb_life_engine.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared constants and helper functions for the Game of Life engine and
// the board address counter.
package life_pkg;

  localparam int LOG2X = 3;
  localparam int LOG2Y = 3;
  localparam int X     = 1 << LOG2X;
  localparam int Y     = 1 << LOG2Y;
  localparam int CELLS = X * Y;
  localparam int AW    = LOG2X + LOG2Y;
  localparam int CW    = AW + 1;

  // Generation control: idle between runs, or collecting strobes of a run.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_e;

  // Wrapped neighbour index. Row and column offsets are truncated to the
  // index width, so the natural modulo arithmetic gives toroidal wrap.
  function automatic logic [AW-1:0] neigh_idx(input logic [AW-1:0] a,
                                               input int dr,
                                               input int dc);
    logic [LOG2Y-1:0] r;
    logic [LOG2X-1:0] c;
    r = a[AW-1:LOG2X] + LOG2Y'(dr);
    c = a[LOG2X-1:0] + LOG2X'(dc);
    return {r, c};
  endfunction

  // B3/S23: birth on exactly 3 neighbours, survival on 2 or 3.
  function automatic logic next_state(input logic alive, input logic [3:0] n);
    return (n == 4'd3) || (alive && (n == 4'd2));
  endfunction

endpackage

// File: rtl/life_popcnt.sv
// Combinational population count of a packed bit vector.
module life_popcnt #(
  parameter int WIDTH = 64,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CW-1:0]    count_o
);

  // Plain ripple sum; synthesis rebalances it into an adder tree.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count_o = count_o + CW'(data_i[i]);
    end
  end

endmodule

// File: rtl/life_engine.sv
// Game of Life generation engine for a toroidal board.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no run in progress; a strobe starts a run (shadow preload)
//   ST_RUN  | collecting strobes; a low strobe commits shadow to board
//
// The geometry parameters must agree with the constants in life_pkg, since
// the neighbour and rule helpers are shared with the address counter.
module life_engine
  import life_pkg::*;
#(
  parameter int X     = life_pkg::X,
  parameter int Y     = life_pkg::Y,
  parameter int LOG2X = life_pkg::LOG2X,
  parameter int LOG2Y = life_pkg::LOG2Y
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     step_en,
  input  logic [LOG2X+LOG2Y-1:0]   addr,
  input  logic                     load_en,
  input  logic [X*Y-1:0]           load_data,
  output logic [X*Y-1:0]           board,
  output logic                     gen_done,
  output logic                     busy,
  output logic [15:0]              gen_cnt,
  output logic [LOG2X+LOG2Y:0]     live_cnt
);

  run_state_e       state_q;
  logic [CELLS-1:0] board_q;
  logic [CELLS-1:0] shadow_q;
  logic [CELLS-1:0] shadow_d;
  logic [CW-1:0]    eval_cnt_q;
  logic [CW-1:0]    live_cnt_q;
  logic [15:0]      gen_cnt_q;
  logic             gen_done_q;

  logic [3:0]       n_live;
  logic             cell_next;
  logic [CELLS-1:0] pop_src;
  logic [CW-1:0]    pop_cnt;

  // Neighbour count and rule for the strobed cell, always read from the
  // committed board so the whole run sees one frozen generation.
  always_comb begin
    n_live = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (!(dr == 0 && dc == 0)) begin
          n_live = n_live + 4'(board_q[neigh_idx(addr, dr, dc)]);
        end
      end
    end
    cell_next = next_state(board_q[addr], n_live);
  end

  // Shadow update: the first strobe of a run starts from the committed board
  // so never-strobed cells carry over unchanged.
  always_comb begin
    shadow_d       = (state_q == ST_RUN) ? shadow_q : board_q;
    shadow_d[addr] = cell_next;
  end

  // Load and commit never coincide (load wins), so one counter serves both.
  assign pop_src = load_en ? load_data : shadow_q;

  life_popcnt #(
    .WIDTH (CELLS),
    .CW    (CW)
  ) u_popcnt (
    .data_i  (pop_src),
    .count_o (pop_cnt)
  );

  // Run/commit control, board, shadow and statistics.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      board_q    <= '0;
      shadow_q   <= '0;
      eval_cnt_q <= '0;
      live_cnt_q <= '0;
      gen_cnt_q  <= '0;
      gen_done_q <= 1'b0;
    end else if (load_en) begin
      // Aborting here makes any strobes that follow a fresh run.
      state_q    <= ST_IDLE;
      board_q    <= load_data;
      live_cnt_q <= pop_cnt;
      gen_cnt_q  <= '0;
      eval_cnt_q <= '0;
      gen_done_q <= 1'b0;
    end else begin
      gen_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (step_en) begin
            shadow_q   <= shadow_d;
            eval_cnt_q <= CW'(1);
            state_q    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (step_en) begin
            shadow_q   <= shadow_d;
            eval_cnt_q <= eval_cnt_q + CW'(1);
          end else begin
            board_q    <= shadow_q;
            live_cnt_q <= pop_cnt;
            gen_cnt_q  <= gen_cnt_q + 16'd1;
            gen_done_q <= 1'b1;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign board    = board_q;
  assign gen_done = gen_done_q;
  assign busy     = (state_q == ST_RUN);
  assign gen_cnt  = gen_cnt_q;
  assign live_cnt = live_cnt_q;

endmodule

// File: tb/tb_life_engine.sv
// Directed bench for life_engine on the default 8x8 board.
module tb_life_engine;

  logic        clk;
  logic        reset;
  logic        step_en;
  logic [5:0]  addr;
  logic        load_en;
  logic [63:0] load_data;
  logic [63:0] board;
  logic        gen_done;
  logic        busy;
  logic [15:0] gen_cnt;
  logic [6:0]  live_cnt;

  int total  = 0;
  int passed = 0;
  int pulses = 0;
  int busy_cycles = 0;

  localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
  localparam logic [63:0] BLOCK   = 64'h0000_0000_1818_0000;
  // Horizontal blinker centred on column 0 of row 0 (cells 7,0,1) turns
  // vertical through column 0 across rows 7,0,1: cells 56, 0, 8.
  localparam logic [63:0] WRAP_IN  = 64'h0000_0000_0000_0083;
  localparam logic [63:0] WRAP_OUT = 64'h0100_0000_0000_0101;
  // Blinker run restarted at addr 20: cell 19 is never evaluated (stays
  // dead), cells 26/28 die, cells 27/35 live.
  localparam logic [63:0] PART_OUT = 64'h0000_0008_0800_0000;

  life_engine dut (
    .clk       (clk),
    .reset     (reset),
    .step_en   (step_en),
    .addr      (addr),
    .load_en   (load_en),
    .load_data (load_data),
    .board     (board),
    .gen_done  (gen_done),
    .busy      (busy),
    .gen_cnt   (gen_cnt),
    .live_cnt  (live_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (gen_done) pulses++;
    if (busy) busy_cycles++;
  endtask

  task automatic strobe(input int a);
    step_en = 1'b1;
    addr    = 6'(a);
    tick();
  endtask

  task automatic end_run();
    step_en = 1'b0;
    tick();
  endtask

  task automatic steady_run();
    strobe(63);
    for (int a = 0; a < 63; a++) strobe(a);
    end_run();
  endtask

  task automatic load(input logic [63:0] seed);
    load_en   = 1'b1;
    load_data = seed;
    tick();
    load_en   = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    step_en   = 1'b0;
    addr      = '0;
    load_en   = 1'b0;
    load_data = '0;
    tick();
    tick();
    check("rst_board",    board,    64'h0);
    check("rst_gen_done", 64'(gen_done), 64'h0);
    check("rst_busy",     64'(busy),     64'h0);
    check("rst_gen_cnt",  64'(gen_cnt),  64'h0);
    check("rst_live_cnt", 64'(live_cnt), 64'h0);

    // Post-reset sweep: 63 strobes on addr 0..62.
    reset = 1'b1;
    pulses = 0;
    busy_cycles = 0;
    for (int a = 0; a < 63; a++) strobe(a);
    check("sweep_no_early_done", 64'(pulses), 64'd0);
    end_run();
    check("sweep_done",     64'(gen_done), 64'h1);
    check("sweep_board",    board,         64'h0);
    check("sweep_gen_cnt",  64'(gen_cnt),  64'd1);
    check("sweep_live_cnt", 64'(live_cnt), 64'd0);
    tick();
    check("sweep_done_1cyc", 64'(gen_done), 64'h0);
    check("sweep_busy_cycles", 64'(busy_cycles), 64'd63);

    // Blinker.
    load(BLINK_H);
    check("blink_load_board", board,         BLINK_H);
    check("blink_load_gen",   64'(gen_cnt),  64'd0);
    check("blink_load_live",  64'(live_cnt), 64'd3);
    pulses = 0;
    steady_run();
    check("blink1_done",  64'(gen_done), 64'h1);
    check("blink1_board", board,         BLINK_V);
    check("blink1_gen",   64'(gen_cnt),  64'd1);
    check("blink1_live",  64'(live_cnt), 64'd3);
    check("blink1_pulses", 64'(pulses),  64'd1);
    steady_run();
    check("blink2_board", board,        BLINK_H);
    check("blink2_gen",   64'(gen_cnt), 64'd2);

    // Block still life.
    load(BLOCK);
    pulses = 0;
    steady_run();
    steady_run();
    steady_run();
    check("block_board",  board,         BLOCK);
    check("block_live",   64'(live_cnt), 64'd4);
    check("block_gen",    64'(gen_cnt),  64'd3);
    check("block_pulses", 64'(pulses),   64'd3);

    // Toroidal wrap.
    load(WRAP_IN);
    steady_run();
    check("wrap_board", board,         WRAP_OUT);
    check("wrap_live",  64'(live_cnt), 64'd3);

    // Load mid-run: the 21st strobe (addr 19) coincides with load_en.
    pulses = 0;
    strobe(63);
    for (int a = 0; a < 19; a++) strobe(a);
    load_en   = 1'b1;
    load_data = BLINK_H;
    strobe(19);
    load_en   = 1'b0;
    check("midload_busy",  64'(busy),    64'h0);
    check("midload_board", board,        BLINK_H);
    check("midload_gen",   64'(gen_cnt), 64'd0);
    for (int a = 20; a < 63; a++) strobe(a);
    check("midload_no_done", 64'(pulses), 64'd0);
    end_run();
    check("midload_commit_board", board,         PART_OUT);
    check("midload_commit_gen",   64'(gen_cnt),  64'd1);
    check("midload_commit_live",  64'(live_cnt), 64'd2);
    check("midload_pulses",       64'(pulses),   64'd1);

    // Reset mid-run after one committed generation.
    load(BLINK_H);
    steady_run();
    check("prerst_gen", 64'(gen_cnt), 64'd1);
    pulses = 0;
    strobe(63);
    for (int a = 0; a < 29; a++) strobe(a);
    #2 reset = 1'b0;
    #1;
    check("midrst_board", board,         64'h0);
    check("midrst_busy",  64'(busy),     64'h0);
    check("midrst_gen",   64'(gen_cnt),  64'h0);
    check("midrst_live",  64'(live_cnt), 64'h0);
    check("midrst_done",  64'(gen_done), 64'h0);
    strobe(29);
    strobe(30);
    step_en = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    tick();
    check("midrst_pulses", 64'(pulses),  64'd0);
    check("midrst_after_board", board,   64'h0);
    check("midrst_after_gen", 64'(gen_cnt), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
